// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter.
// Holds the CPU-access FSM state encoding and the default VRAM geometry.
// No ports: this package is imported by vram_arbiter.
package vram_arb_pkg;

  // Default VRAM geometry: 8K x 8.
  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 8;

  // CPU access sequencing:
  //   IDLE - waiting for a CPU request
  //   PEND - request latched, waiting for a cycle video does not own
  //   DATA - RAM read data for the CPU access is on ram_q
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port video RAM between the video fetch
// engine and a CPU, with absolute priority for video. Also holds the border
// colour register and the vertical-retrace interrupt flag.
//
// Ports:
//   clock, reset_n          - clock and synchronous active-low reset
//   vga_fetch, vga_a, vga_i - video fetch strobe, address, read data
//   vretrace                - one-cycle end-of-frame pulse (sets irq)
//   cpu_req, cpu_we, cpu_a, cpu_d, cpu_q, cpu_ready
//                           - CPU request, direction, address, write data,
//                             registered read data, completion pulse
//   io_we, io_d, border     - border register write strobe, data, value
//   irq, irq_ack            - retrace interrupt level and acknowledge
//   ram_a, ram_d, ram_we, ram_q
//                           - single-port RAM interface (ram_q is valid the
//                             cycle after ram_a is presented)
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          vga_fetch,
  input  logic [AW-1:0] vga_a,
  output logic [DW-1:0] vga_i,
  input  logic          vretrace,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ready,
  input  logic          io_we,
  input  logic [2:0]    io_d,
  output logic [2:0]    border,
  output logic          irq,
  input  logic          irq_ack,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  arb_state_t    state;
  logic [AW-1:0] req_a;
  logic [DW-1:0] req_d;
  logic          req_we;
  logic          cpu_slot;

  // The CPU gets the RAM only in PEND when video is not fetching. Gating with
  // reset_n keeps a latched write from reaching the RAM during reset and
  // hands the address bus back to video.
  assign cpu_slot = reset_n && (state == PEND) && !vga_fetch;

  assign ram_a  = cpu_slot ? req_a : vga_a;
  assign ram_d  = req_d;
  assign ram_we = cpu_slot && req_we;

  // Video data comes straight from the RAM; the fetch cycle's address is
  // always on ram_a, so ram_q is video data the following cycle.
  assign vga_i = ram_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_a     <= '0;
      req_d     <= '0;
      req_we    <= 1'b0;
      cpu_q     <= '0;
      cpu_ready <= 1'b0;
      border    <= 3'b000;
      irq       <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_a  <= cpu_a;
            req_d  <= cpu_d;
            req_we <= cpu_we;
            state  <= PEND;
          end
        end
        PEND: begin
          // Each video fetch cycle here stalls the CPU by one cycle.
          if (!vga_fetch) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (!req_we) begin
            cpu_q <= ram_q;
          end
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (io_we) begin
        border <= io_d;
      end

      // A new retrace takes precedence over an acknowledge in the same cycle
      // so an interrupt is never lost.
      if (vretrace) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural single-port RAM.
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          vga_fetch;
  logic [AW-1:0] vga_a;
  logic [DW-1:0] vga_i;
  logic          vretrace;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d;
  logic [DW-1:0] cpu_q;
  logic          cpu_ready;
  logic          io_we;
  logic [2:0]    io_d;
  logic [2:0]    border;
  logic          irq;
  logic          irq_ack;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .vga_fetch(vga_fetch), .vga_a(vga_a), .vga_i(vga_i), .vretrace(vretrace),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_ready(cpu_ready),
    .io_we(io_we), .io_d(io_d), .border(border),
    .irq(irq), .irq_ack(irq_ack),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // RAM model: synchronous read, write-through on ram_we, plus a preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clock) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  int checks = 0;
  int failures = 0;
  int n;
  int reads;
  int nxt;
  logic vid_due;
  logic done;
  logic saw_ready;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] vid_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; vga_fetch = 1'b0; vga_a = 13'h0ABC; vretrace = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 13'h0040; cpu_d = 8'hEE;
    io_we = 1'b0; io_d = 3'b000; irq_ack = 1'b0;
    step();
    step();

    // Reset state; a write request during reset must not reach the RAM.
    check("reset_cpu_ready", 32'(cpu_ready), 32'd0);
    check("reset_cpu_q", 32'(cpu_q), 32'h0);
    check("reset_border", 32'(border), 32'h0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_ram_we", 32'(ram_we), 32'd0);
    check("reset_ram_a", 32'(ram_a), 32'h0ABC);
    cpu_req = 1'b0;

    preload(13'h0123, 8'h5A);
    preload(13'h0010, 8'h33);
    for (int i = 0; i < 16; i++) preload(13'h0200 + 13'(i), 8'h40 + 8'(i * 3));

    vga_a = 13'h0000;
    reset_n = 1'b1;
    step();

    // Idle-bus read: ready exactly 3 cycles after the request cycle.
    exp_q.push_back(8'h5A);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 13'h0123;
    step();
    cpu_req = 1'b0;
    n = 1;
    while (!cpu_ready && n < 10) begin step(); n++; end
    check("read_latency", 32'(n), 32'd3);
    check("read_data", 32'(cpu_q), 32'(exp_q.pop_front()));
    step();
    check("read_ready_pulse", 32'(cpu_ready), 32'd0);

    // Conflict write: two video fetch cycles while the write is pending.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 13'h1800; cpu_d = 8'h47;
    step();
    cpu_req = 1'b0;
    vga_fetch = 1'b1; vga_a = 13'h0201;
    vid_q.push_back(mem[13'h0201]);
    #1;
    check("conflict_ram_a_1", 32'(ram_a), 32'h0201);
    check("conflict_ram_we_1", 32'(ram_we), 32'd0);
    step();
    check("conflict_vga_i", 32'(vga_i), 32'(vid_q.pop_front()));
    vga_a = 13'h0202;
    #1;
    check("conflict_ram_a_2", 32'(ram_a), 32'h0202);
    check("conflict_ram_we_2", 32'(ram_we), 32'd0);
    step();
    vga_fetch = 1'b0; vga_a = 13'h0300;
    #1;
    check("conflict_ram_we", 32'(ram_we), 32'd1);
    check("conflict_ram_a", 32'(ram_a), 32'h1800);
    check("conflict_ram_d", 32'(ram_d), 32'h47);
    n = 3;
    while (!cpu_ready && n < 12) begin step(); n++; end
    check("write_latency", 32'(n), 32'd5);
    check("write_keeps_cpu_q", 32'(cpu_q), 32'h5A);
    step();
    check("write_mem", 32'(mem[13'h1800]), 32'h47);

    // Video integrity under a continuous CPU read stream.
    cpu_we = 1'b0; nxt = 0; reads = 0; vid_due = 1'b0;
    cpu_a = 13'h0208;
    exp_q.push_back(mem[13'h0208]);
    cpu_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (vid_due) begin
        check("video_data", 32'(vga_i), 32'(vid_q.pop_front()));
        vid_due = 1'b0;
      end
      if (cpu_ready) begin
        check("stream_data", 32'(cpu_q), 32'(exp_q.pop_front()));
        reads++;
        nxt++;
        cpu_a = 13'h0208 + 13'(nxt);
        exp_q.push_back(mem[cpu_a]);
      end
      vga_a = 13'h0200 + 13'(i);
      vga_fetch = (i == 4 || i == 9);
      if (vga_fetch) begin
        vid_q.push_back(mem[vga_a]);
        vid_due = 1'b1;
        #1;
        check("video_ram_a", 32'(ram_a), 32'(vga_a));
        check("video_ram_we", 32'(ram_we), 32'd0);
      end
      step();
    end
    vga_fetch = 1'b0;
    if (vid_due) check("video_data_last", 32'(vga_i), 32'(vid_q.pop_front()));
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      if (cpu_ready) begin
        check("stream_data_last", 32'(cpu_q), 32'(exp_q.pop_front()));
        reads++;
        cpu_req = 1'b0;
        done = 1'b1;
      end else begin
        step();
      end
    end
    check("stream_drained", 32'(done), 32'd1);
    check("stream_enough_reads", 32'(reads >= 5), 32'd1);
    step();
    step();

    // Interrupt set, hold, acknowledge, and set-wins-over-ack.
    vretrace = 1'b1; step(); vretrace = 1'b0;
    check("irq_set", 32'(irq), 32'd1);
    step(); step();
    check("irq_hold", 32'(irq), 32'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("irq_ack_clear", 32'(irq), 32'd0);
    vretrace = 1'b1; irq_ack = 1'b1; step();
    check("irq_set_wins_from_0", 32'(irq), 32'd1);
    step(); vretrace = 1'b0; irq_ack = 1'b0;
    check("irq_set_wins_from_1", 32'(irq), 32'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("irq_ack_clear_2", 32'(irq), 32'd0);

    // Border register.
    io_d = 3'b101; io_we = 1'b1;
    #1;
    check("border_before_edge", 32'(border), 32'h0);
    step();
    io_we = 1'b0; io_d = 3'b010;
    check("border_load", 32'(border), 32'h5);
    step(); step();
    check("border_hold", 32'(border), 32'h5);
    io_we = 1'b1; step(); io_we = 1'b0;
    check("border_reload", 32'(border), 32'h2);
    io_d = 3'b101; io_we = 1'b1; step(); io_we = 1'b0;
    vretrace = 1'b1; step(); vretrace = 1'b0;

    // Reset while a write is pending.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 13'h0010; cpu_d = 8'hFF; vga_a = 13'h0777;
    step();
    cpu_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_pend_ram_we", 32'(ram_we), 32'd0);
    check("rst_pend_ram_a", 32'(ram_a), 32'h0777);
    step(); step();
    reset_n = 1'b1;
    saw_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (cpu_ready) saw_ready = 1'b1;
    end
    check("rst_no_ready", 32'(saw_ready), 32'd0);
    check("rst_mem_kept", 32'(mem[13'h0010]), 32'h33);
    check("rst_border", 32'(border), 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cpu_q", 32'(cpu_q), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
